rs232_tx_arbiter: RTL and testbench

//  Shares one RS232 transmit path (serializer + its 128-deep TX FIFO) among NUM_REQ clients.

---
 rtl/rs232_pkg.sv | 6 +
 rtl/rs232_tx_arbiter_rr_pick.sv | 21 ++
 rtl/rs232_tx_arbiter.sv | 88 ++++++++
 tb/tb_rs232_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared state type and constants for the RS232 transmit arbiter
package rs232_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  localparam int DEF_DATA_WIDTH = 9;
  localparam int FIFO_DEPTH = 128;
endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// rs232_rr_pick: rotate-priority picker returning the first requester at or after ptr
module rs232_rr_pick
  import rs232_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = PW'((int'(ptr) + k) % N);
    any = |req;
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin packet arbiter sharing one RS232 transmit FIFO among clients
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SPACE_MARGIN = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [7:0]                    fifo_write_space,
  output logic [DATA_WIDTH-1:0]         transmit_data,
  output logic                          transmit_data_en,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_pulse,
  output logic [2:0]                    timeout_id
);
  localparam int PW = $clog2(NUM_REQ);
  state_t state;
  logic [PW-1:0] rr_ptr, gidx, pick_idx, nxt_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic pick_any, space_ok, acc, to_hit;
  logic [TO_WIDTH-1:0] to_cnt;
  rs232_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .onehot(pick_onehot),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    space_ok = fifo_write_space > 8'(SPACE_MARGIN);
    req_ready = (state == XFER && space_ok) ? grant : '0;
    acc = state == XFER && space_ok && req_valid[gidx];
    to_hit = TIMEOUT_CYCLES != 0 && to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1);
    nxt_ptr = gidx == PW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      busy <= 1'b0;
      transmit_data <= '0;
      transmit_data_en <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_id <= '0;
      rr_ptr <= '0;
      to_cnt <= '0;
    end else begin
      transmit_data_en <= acc;
      timeout_pulse <= 1'b0;
      if (acc) transmit_data <= req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      if (state == IDLE) begin
        if (pick_any) begin
          state <= XFER;
          busy <= 1'b1;
          grant <= pick_onehot;
          gidx <= pick_idx;
          to_cnt <= '0;
        end
      end else if (acc && req_last[gidx]) begin
        state <= IDLE;
        busy <= 1'b0;
        grant <= '0;
        rr_ptr <= nxt_ptr;
      end else if (req_valid[gidx]) begin
        to_cnt <= '0;
      end else if (to_hit) begin
        state <= IDLE;
        busy <= 1'b0;
        grant <= '0;
        rr_ptr <= nxt_ptr;
        timeout_pulse <= 1'b1;
        timeout_id <= 3'(gidx);
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb_rs232_tx_arbiter: directed and randomized self-checking bench for the RS232 transmit arbiter
module tb_rs232_tx_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [35:0] req_data = '0;
  logic [3:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [7:0] fifo_write_space = 8'd128;
  logic [8:0] transmit_data;
  logic transmit_data_en, busy, timeout_pulse;
  logic [2:0] timeout_id;
  logic [9:0] src_q[4][$];
  logic [9:0] exp_q[4][$];
  int checks = 0, errors = 0;
  rs232_tx_arbiter dut (
    .clk(clk),
    .reset(reset),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .fifo_write_space(fifo_write_space),
    .transmit_data(transmit_data),
    .transmit_data_en(transmit_data_en),
    .grant(grant),
    .busy(busy),
    .timeout_pulse(timeout_pulse),
    .timeout_id(timeout_id)
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #2;
  endtask
  task drive(input int i, input logic v, input logic l, input logic [8:0] d);
    req_valid[i] = v;
    req_last[i] = l;
    req_data[i*9 +: 9] = d;
  endtask
  task do_reset;
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_write_space = 8'd128;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask
  task test_reset;
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_write_space = 8'd128;
    tick;
    tick;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (transmit_data_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", transmit_data_en); end
    checks++; if (transmit_data !== 9'h0) begin errors++; $display("FAIL reset_data got %h exp 000", transmit_data); end
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", timeout_pulse); end
    checks++; if (timeout_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", timeout_id); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    reset = 1'b0;
    tick;
  endtask
  task test_single;
    drive(1, 1'b1, 1'b0, 9'h101);
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_idle_ready got %b exp 0000", req_ready); end
    tick;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    checks++; if (transmit_data_en !== 1'b0) begin errors++; $display("FAIL single_en_early got %b exp 0", transmit_data_en); end
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b exp 0010", req_ready); end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, k == 2, 9'(9'h101 + k));
      tick;
      checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'(9'h101 + k)) begin errors++; $display("FAIL single_beat%0d got en %b data %h exp en 1 data %h", k, transmit_data_en, transmit_data, 9'(9'h101 + k)); end
    end
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got grant %b busy %b exp 0000 0", grant, busy); end
    drive(1, 1'b0, 1'b0, 9'h0);
    tick;
    checks++; if (transmit_data_en !== 1'b0) begin errors++; $display("FAIL single_en_after got %b exp 0", transmit_data_en); end
  endtask
  task test_two_clients;
    do_reset;
    drive(0, 1'b1, 1'b0, 9'h0A0);
    drive(2, 1'b1, 1'b0, 9'h0C0);
    tick;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL two_grant0 got %b exp 0001", grant); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL two_ready_others got %b exp 0001", req_ready); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0A0) begin errors++; $display("FAIL two_a0 got en %b data %h exp en 1 data 0a0", transmit_data_en, transmit_data); end
    drive(0, 1'b1, 1'b1, 9'h0A1);
    tick;
    checks++; if (transmit_data !== 9'h0A1 || grant !== 4'b0) begin errors++; $display("FAIL two_a1 got data %h grant %b exp 0a1 0000", transmit_data, grant); end
    drive(0, 1'b0, 1'b0, 9'h0);
    tick;
    checks++; if (grant !== 4'b0100 || transmit_data_en !== 1'b0) begin errors++; $display("FAIL two_grant2 got grant %b en %b exp 0100 0", grant, transmit_data_en); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0C0) begin errors++; $display("FAIL two_c0 got en %b data %h exp en 1 data 0c0", transmit_data_en, transmit_data); end
    drive(2, 1'b1, 1'b1, 9'h0C1);
    tick;
    checks++; if (transmit_data !== 9'h0C1 || grant !== 4'b0) begin errors++; $display("FAIL two_c1 got data %h grant %b exp 0c1 0000", transmit_data, grant); end
    drive(2, 1'b0, 1'b0, 9'h0);
    drive(0, 1'b1, 1'b1, 9'h0A2);
    drive(3, 1'b1, 1'b1, 9'h0D0);
    tick;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL two_ptr3_grant got %b exp 1000", grant); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0D0 || grant !== 4'b0) begin errors++; $display("FAIL two_d0 got en %b data %h grant %b exp 1 0d0 0000", transmit_data_en, transmit_data, grant); end
    drive(3, 1'b0, 1'b0, 9'h0);
    tick;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL two_wrap_grant got %b exp 0001", grant); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0A2) begin errors++; $display("FAIL two_a2 got en %b data %h exp 1 0a2", transmit_data_en, transmit_data); end
    drive(0, 1'b0, 1'b0, 9'h0);
    tick;
  endtask
  task test_space;
    drive(0, 1'b1, 1'b0, 9'h0E0);
    tick;
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0E0) begin errors++; $display("FAIL space_e0 got en %b data %h exp 1 0e0", transmit_data_en, transmit_data); end
    drive(0, 1'b1, 1'b0, 9'h0E1);
    fifo_write_space = 8'd2;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL space2_ready got %b exp 0000", req_ready); end
    tick;
    checks++; if (transmit_data_en !== 1'b0) begin errors++; $display("FAIL space2_en got %b exp 0", transmit_data_en); end
    tick;
    checks++; if (transmit_data_en !== 1'b0) begin errors++; $display("FAIL space2_en2 got %b exp 0", transmit_data_en); end
    fifo_write_space = 8'd3;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL space3_ready got %b exp 0001", req_ready); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0E1) begin errors++; $display("FAIL space_e1 got en %b data %h exp 1 0e1", transmit_data_en, transmit_data); end
    drive(0, 1'b1, 1'b1, 9'h0E2);
    fifo_write_space = 8'd0;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL space0_ready got %b exp 0000", req_ready); end
    tick;
    checks++; if (transmit_data_en !== 1'b0) begin errors++; $display("FAIL space0_en got %b exp 0", transmit_data_en); end
    fifo_write_space = 8'd128;
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0E2 || grant !== 4'b0) begin errors++; $display("FAIL space_e2 got en %b data %h grant %b exp 1 0e2 0000", transmit_data_en, transmit_data, grant); end
    drive(0, 1'b0, 1'b0, 9'h0);
    tick;
  endtask
  task test_timeout;
    int bad;
    bad = 0;
    drive(3, 1'b1, 1'b0, 9'h0F0);
    tick;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL to_grant3 got %b exp 1000", grant); end
    drive(0, 1'b1, 1'b1, 9'h0B0);
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0F0) begin errors++; $display("FAIL to_f0 got en %b data %h exp 1 0f0", transmit_data_en, transmit_data); end
    drive(3, 1'b0, 1'b0, 9'h0);
    for (int n = 0; n < 4095; n++) begin
      tick;
      if (timeout_pulse !== 1'b0 || grant !== 4'b1000 || transmit_data_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_hold got %0d bad cycles exp 0", bad); end
    tick;
    checks++; if (timeout_pulse !== 1'b1 || timeout_id !== 3'd3) begin errors++; $display("FAIL to_pulse got pulse %b id %0d exp 1 3", timeout_pulse, timeout_id); end
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_release got grant %b busy %b exp 0000 0", grant, busy); end
    tick;
    checks++; if (timeout_pulse !== 1'b0 || grant !== 4'b0001 || timeout_id !== 3'd3) begin errors++; $display("FAIL to_next got pulse %b grant %b id %0d exp 0 0001 3", timeout_pulse, grant, timeout_id); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h0B0) begin errors++; $display("FAIL to_b0 got en %b data %h exp 1 0b0", transmit_data_en, transmit_data); end
    drive(0, 1'b0, 1'b0, 9'h0);
    tick;
  endtask
  task test_reset_mid;
    drive(2, 1'b1, 1'b0, 9'h070);
    tick;
    tick;
    checks++; if (transmit_data_en !== 1'b1 || grant !== 4'b0100) begin errors++; $display("FAIL rst_pre got en %b grant %b exp 1 0100", transmit_data_en, grant); end
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0 || transmit_data_en !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL rst_async got grant %b en %b busy %b ready %b exp 0000 0 0 0000", grant, transmit_data_en, busy, req_ready); end
    drive(2, 1'b0, 1'b0, 9'h0);
    drive(0, 1'b1, 1'b1, 9'h072);
    drive(1, 1'b1, 1'b1, 9'h071);
    tick;
    reset = 1'b0;
    tick;
    checks++; if (grant !== 4'b0001 || transmit_data_en !== 1'b0) begin errors++; $display("FAIL rst_regrant got grant %b en %b exp 0001 0", grant, transmit_data_en); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h072) begin errors++; $display("FAIL rst_072 got en %b data %h exp 1 072", transmit_data_en, transmit_data); end
    drive(0, 1'b0, 1'b0, 9'h0);
    tick;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rst_grant1 got %b exp 0010", grant); end
    tick;
    checks++; if (transmit_data_en !== 1'b1 || transmit_data !== 9'h071) begin errors++; $display("FAIL rst_071 got en %b data %h exp 1 071", transmit_data_en, transmit_data); end
    drive(1, 1'b0, 1'b0, 9'h0);
    tick;
  endtask
  task test_random;
    int occ, occ_rep, cur, prev, delivered, total, c, cycles, seq, len;
    logic [3:0] acc;
    logic [9:0] e;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      seq = 0;
      for (int p = 0; p < 8; p++) begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          e = {b == len - 1, 2'(i), 7'(seq)};
          src_q[i].push_back(e);
          exp_q[i].push_back(e);
          seq++;
          total++;
        end
      end
    end
    occ = 110;
    occ_rep = 110;
    fifo_write_space = 8'(128 - occ);
    cur = -1;
    prev = -1;
    delivered = 0;
    cycles = 0;
    while (delivered < total && cycles < 20000) begin
      for (int i = 0; i < 4; i++) begin
        e = src_q[i].size() != 0 ? src_q[i][0] : 10'h0;
        req_valid[i] = src_q[i].size() != 0 && $urandom_range(0, 3) != 0;
        req_last[i] = e[9];
        req_data[i*9 +: 9] = e[8:0];
      end
      #1;
      acc = req_valid & req_ready;
      tick;
      cycles++;
      for (int i = 0; i < 4; i++)
        if (acc[i]) void'(src_q[i].pop_front());
      if (transmit_data_en === 1'b1) begin
        c = int'(transmit_data[8:7]);
        checks++; if (occ >= 128) begin errors++; $display("FAIL rand_overflow got occupancy %0d exp below 128", occ); end
        occ++;
        e = 10'h0;
        checks++;
        if (exp_q[c].size() == 0) begin errors++; $display("FAIL rand_data got %h exp none pending", transmit_data); end
        else begin
          e = exp_q[c].pop_front();
          if (transmit_data !== e[8:0]) begin errors++; $display("FAIL rand_data got %h exp %h", transmit_data, e[8:0]); end
        end
        checks++; if ((cur != -1 && c != cur) || (prev != -1 && prev != c)) begin errors++; $display("FAIL rand_interleave got client %0d exp client %0d prev %0d", c, cur, prev); end
        cur = e[9] ? -1 : c;
        prev = c;
        delivered++;
      end else prev = -1;
      fifo_write_space = 8'(128 - occ_rep);
      if (occ > 0 && $urandom_range(0, 3) == 0) occ--;
      occ_rep = occ;
    end
    checks++; if (delivered != total) begin errors++; $display("FAIL rand_complete got %0d beats exp %0d", delivered, total); end
    req_valid = '0;
    req_last = '0;
    fifo_write_space = 8'd128;
    tick;
    tick;
  endtask
  initial begin
    test_reset;
    test_single;
    test_two_clients;
    test_space;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
